// File: rtl/fft_input_buffer.sv
// rtl/fft_input_buffer.sv - 8-sample bit-reversed staging buffer feeding the FFT first stage
module fft_input_buffer #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [8*DATA_W-1:0]   frame_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_err
);

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [DATA_W-1:0] slots [8];
    logic              acc;

    // Sample index n lands in slot bitrev(n) so the FFT sees natural-order outputs.
    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    // Handshake outputs come straight from the state register, never from inputs.
    assign in_ready  = (state == LOAD);
    assign out_valid = (state == FULL);
    assign acc       = in_valid & in_ready;

    // Flatten the slot array into the parallel frame word, slot k at the k-th lane.
    always_comb begin
        frame_out = '0;
        for (int k = 0; k < 8; k++) begin
            frame_out[DATA_W*k +: DATA_W] = slots[k];
        end
    end

    // Load/full sequencing, slot writes and sticky framing-error tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LOAD;
            cnt       <= 3'd0;
            frame_err <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                slots[k] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (acc) begin
                        slots[bitrev3(cnt)] <= in_data;
                        if (cnt == 3'd7) begin
                            // Frame is delivered even without its marker; only flag it.
                            cnt   <= 3'd0;
                            state <= FULL;
                            if (!in_last) begin
                                frame_err <= 1'b1;
                            end
                        end else if (in_last) begin
                            // Early marker: drop the partial frame and restart at slot 0.
                            cnt       <= 3'd0;
                            frame_err <= 1'b1;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_input_buffer.sv
// tb/tb_fft_input_buffer.sv - scoreboard bench for fft_input_buffer with a queue-based frame model
module tb_fft_input_buffer;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [15:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [127:0] frame_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         frame_err;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    fft_input_buffer #(.DATA_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .frame_out (frame_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a frame is a list of 8 samples; sample n belongs at
    // position given by reversing the three binary digits of n.
    logic         m_full = 1'b0;
    int           m_idx  = 0;
    logic         m_err  = 1'b0;
    logic [15:0]  m_mem [8];
    logic [127:0] exp_q [$];

    function automatic int rev(input int c);
        return ((c % 2) * 4) + (((c / 2) % 2) * 2) + ((c / 4) % 2);
    endfunction

    function automatic logic [127:0] pack(input logic [15:0] t [8]);
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[16*k +: 16] = t[k];
        return r;
    endfunction

    initial for (int k = 0; k < 8; k++) m_mem[k] = '0;

    always @(posedge clk or negedge reset) begin
        logic [15:0] t [8];
        if (!reset) begin
            m_full <= 1'b0;
            m_idx  <= 0;
            m_err  <= 1'b0;
            for (int k = 0; k < 8; k++) m_mem[k] <= '0;
            exp_q.delete();
        end else if (m_full) begin
            if (out_ready) m_full <= 1'b0;
        end else if (in_valid) begin
            t = m_mem;
            t[rev(m_idx)] = in_data;
            m_mem <= t;
            if (m_idx == 7) begin
                if (!in_last) m_err <= 1'b1;
                exp_q.push_back(pack(t));
                m_full <= 1'b1;
                m_idx  <= 0;
            end else if (in_last) begin
                m_err <= 1'b1;
                m_idx <= 0;
            end else begin
                m_idx <= m_idx + 1;
            end
        end
    end

    // Monitor: compare handshake/flags every cycle, pop a frame on each out_valid rise.
    logic         prev_v = 1'b0;
    logic [127:0] held = '0;
    int           rise_t [$];

    always @(negedge clk) begin
        if (reset) begin
            check("in_ready", in_ready, !m_full);
            check("out_valid", out_valid, m_full);
            check("frame_err", frame_err, m_err);
            if (out_valid && !prev_v) begin
                rise_t.push_back(cycle);
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", 0, 1);
                end else begin
                    held = exp_q.pop_front();
                    check("frame", frame_out, held);
                end
            end else if (out_valid) begin
                check("frame_hold", frame_out, held);
            end
        end
        prev_v = reset && out_valid;
    end

    task automatic send(input logic [15:0] d, input logic l);
        int g = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (m_full && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check("send_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #2 reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_frame_out", frame_out, 0);
        check("rst_frame_err", frame_err, 0);
        reset = 1'b1;

        // Basic frame
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(16'(i), i == 7);
        check("basic_valid", out_valid, 1);
        check("basic_slots", frame_out, 128'h0007_0003_0005_0001_0006_0002_0004_0000);
        idle(1);
        check("basic_one_cycle", out_valid, 0);
        check("basic_err", frame_err, 0);

        // Back-pressure
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(16'h8000 + 16'(i), i == 7);
        in_data = 16'h1234;
        in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_frame", frame_out, 128'h8007_8003_8005_8001_8006_8002_8004_8000);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_slot0", frame_out[15:0], 16'h1234);
        for (int i = 1; i < 8; i++) send(16'h4000 + 16'(i), i == 7);
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(2);

        // Back-to-back frames
        n = rise_t.size();
        for (int i = 0; i < 8; i++) send(16'($urandom), i == 7);
        for (int i = 0; i < 8; i++) send(16'hFFF8 + 16'(i), i == 7);
        check("b2b_valid", out_valid, 1);
        check("b2b_slot1", frame_out[31:16], 16'hFFFC);
        check("b2b_slot7", frame_out[127:112], 16'hFFFF);
        idle(2);
        check("b2b_frames", rise_t.size(), n + 2);
        if (rise_t.size() == n + 2) check("b2b_period", rise_t[n+1] - rise_t[n], 9);

        // Early last
        do_reset();
        send(16'h0A00, 0);
        send(16'h0A01, 0);
        send(16'h0A02, 1);
        check("early_no_valid", out_valid, 0);
        check("early_err", frame_err, 1);
        for (int i = 0; i < 8; i++) send(16'h0B00 + 16'(i), i == 7);
        check("early_next_valid", out_valid, 1);
        check("early_err_sticky", frame_err, 1);
        idle(2);

        // Missing last
        do_reset();
        for (int i = 0; i < 8; i++) send(16'h0C00 + 16'(i), 0);
        check("miss_valid", out_valid, 1);
        check("miss_err", frame_err, 1);
        idle(2);

        // Reset mid-frame
        do_reset();
        for (int i = 0; i < 5; i++) send(16'h0D00 + 16'(i), 0);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("midrst_frame_out", frame_out, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 7; i++) send(16'h0100 + 16'(i), 0);
        check("midrst_not_yet", out_valid, 0);
        send(16'h0107, 1);
        check("midrst_valid", out_valid, 1);
        check("midrst_slot4", frame_out[79:64], 16'h0101);
        idle(2);

        // Randomized traffic with gaps, back-pressure and occasional bad markers
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = 16'($urandom);
            in_last   = (m_idx == 7) ? (($urandom % 10) != 0) : (($urandom % 25) == 0);
            out_ready = ($urandom % 3) != 0;
            @(negedge clk);
        end
        out_ready = 1'b1;
        idle(4);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
